seg7_display_ctrl: RTL
======================

Name: seg7_display_ctrl

Overview:
Display controller directly downstream of the data memory's seven-segment MMIO register, which is written at address 0xC000_0000.
- Captures the 8-bit value stored to that register.
- Renders it on a 3-digit multiplexed common-anode seven-segment display, as two hex digits or as a 0-255 unsigned decimal.
- Decimal mode uses a sequential double-dabble binary-to-BCD converter, so the processor sees only a byte store.

Parameters:
REFRESH_DIV, 50000, clock cycles each digit stays enabled (1 kHz digit rate at 50 MHz); legal range ≥2.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-low reset
load  input  1  one-cycle strobe: value/dec_mode valid (driven from memory store to 0xC000_0000)
value  input  8  byte to display
dec_mode  input  1  1 = unsigned decimal, 0 = hex
busy  output  1  conversion in progress or a load is pending
seg  output  7  {g,f,e,d,c,b,a}, active-low
an  output  3  digit enables, active-low, an[0] = least significant digit

Behaviour:
- Reset (reset==0 at a clk edge):
  - FSM to IDLE; busy=0.
  - Stored digits = 0,0,0; mode = hex; pending cleared.
  - Refresh counter = 0; digit index = 0.
  - an=3'b111, seg=7'b1111111.
  - Reset mid-conversion aborts it with no commit.
- FSM states IDLE, SHIFT, COMMIT:
  - IDLE + load: capture value and dec_mode.
    - Hex: go to COMMIT.
    - Decimal: clear the 12-bit BCD scratch and go to SHIFT with shift count = 0.
  - SHIFT, one bit per cycle, MSB first:
    - Add 3 to each BCD nibble that is ≥5.
    - Then shift {bcd, bin} left 1.
    - After 8 SHIFT cycles go to COMMIT.
  - COMMIT: write the display digit registers.
    - Hex: {0, value[7:4], value[3:0]}.
    - Decimal: BCD hundreds, tens, ones.
    - Then IDLE, or straight to the pending capture if pending is set.
- Latency, load at edge k:
  - Hex: digits updated at edge k+2.
  - Decimal: 8 SHIFT edges k+1..k+8, COMMIT at k+9, digits updated at edge k+10.
- busy:
  - =1 from edge k (the capturing edge) through the COMMIT edge.
  - Held high across back-to-back pending loads.
- load while not IDLE:
  - Stored into a single pending slot; a later load overwrites it (latest wins).
  - The current conversion is never disturbed.
  - COMMIT with pending set clears pending and processes it exactly like an IDLE load at that edge.
- Multiplex:
  - Refresh counter 0..REFRESH_DIV-1.
  - On wrap, digit index advances 0→1→2→0.
  - an = one-hot-low of the index: 110, 101, 011.
  - seg and an are registered together, so they change on the same edge with no skew.
- Blanking, decimal mode only:
  - Hundreds blank if 0.
  - Tens blank if hundreds and tens are both 0.
  - Ones always shown.
  - Hex mode never blanks.
  - A blanked digit drives seg=7'b1111111 with its anode still enabled.
- Font:
  - 0=1000000, 1=1111001, 2=0100100, 5=0010010, 7=1111000, A=0001000.
  - Full 0-F table lives in the package.
- Display always shows the last committed digits; no intermediate BCD values ever appear.

Decomposition:
- Package seg7_pkg:
  - state enum (IDLE, SHIFT, COMMIT).
  - SEG_BLANK constant.
  - 16-entry hex-to-segment localparam table.
  - digit-count constant (3).
- Sub-module hex_to_seg7: combinational 4-bit nibble + blank → seg[6:0]. Instantiated once after the digit mux.

Test Plan:
- Reset: hold reset=0 for 3 cycles → an=111, seg=1111111, busy=0. Release → first enabled digit an=110 showing "0" (1000000).
- Hex load value=0xA5, dec_mode=0, REFRESH_DIV=4:
  - busy high for 2 cycles.
  - an=110 → seg 0010010; an=101 → 0001000; an=011 → 1000000.
  - Each digit held 4 cycles.
- Decimal load value=8'd255: busy high exactly 10 cycles; digits become 2,5,5 (0100100, 0010010, 0010010), with no intermediate value visible.
- Decimal value=8'd7: ones=1111000; tens and hundreds blank (1111111). Then value=8'd0 → ones "0", others blank.
- Load 8'd200 decimal, then loads 0x11 and 0x3C hex during SHIFT:
  - 200 commits first.
  - 0x3C processed next; 0x11 never displayed.
  - busy continuous until the 0x3C commit.
- Reset asserted at SHIFT cycle 4 of a 255 conversion → digits 0,0,0; busy=0; no commit of 255 afterwards.

Source files
------------

// File: rtl/seg7_pkg.sv
// seg7_pkg: shared state type, font table and helpers for the seven-segment display controller.
package seg7_pkg;
    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;
    localparam int NUM_DIGITS = 3;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    // Active-low {g,f,e,d,c,b,a} glyphs for 0-F.
    localparam logic [6:0] SEG_FONT [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    function automatic logic [3:0] add3(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction
endpackage

// File: rtl/hex_to_seg7.sv
// hex_to_seg7: nibble to active-low segment pattern, with a blanking override.
module hex_to_seg7 import seg7_pkg::*; (
    input  logic [3:0] i_nibble,
    input  logic       i_blank,
    output logic [6:0] o_seg
);
    always_comb o_seg = i_blank ? SEG_BLANK : SEG_FONT[i_nibble];
endmodule

// File: rtl/seg7_display_ctrl.sv
// seg7_display_ctrl: captures a stored byte and shows it on a 3-digit multiplexed
// common-anode display as hex or as blank-suppressed unsigned decimal.
module seg7_display_ctrl import seg7_pkg::*; #(
    parameter int REFRESH_DIV = 50000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [7:0]            value,
    input  logic                  dec_mode,
    output logic                  busy,
    output logic [6:0]            seg,
    output logic [NUM_DIGITS-1:0] an
);
    localparam int CW = $clog2(REFRESH_DIV);

    state_t                      r_state;
    logic [7:0]                  r_bin;
    logic [11:0]                 r_bcd;
    logic [2:0]                  r_shift;
    logic                        r_cap_dec;
    logic                        r_pend;
    logic [7:0]                  r_pend_val;
    logic                        r_pend_dec;
    logic [NUM_DIGITS-1:0][3:0]  r_digits;
    logic                        r_disp_dec;
    logic                        r_busy;
    logic [CW-1:0]               r_cnt;
    logic [1:0]                  r_idx;
    logic [6:0]                  r_seg;
    logic [NUM_DIGITS-1:0]       r_an;

    logic                        w_start;
    logic                        w_take_in;
    logic [7:0]                  w_val;
    logic                        w_dec;
    logic [11:0]                 w_adj;
    logic [3:0]                  w_nib;
    logic                        w_blank;
    logic [6:0]                  w_seg;
    logic                        w_wrap;

    // A job starts from the input in IDLE, otherwise from the pending slot (IDLE or COMMIT).
    always_comb begin
        w_take_in = (r_state == IDLE) && load;
        w_start   = w_take_in || (r_state != SHIFT && r_pend);
        w_val     = w_take_in ? value : r_pend_val;
        w_dec     = w_take_in ? dec_mode : r_pend_dec;
        w_adj     = {add3(r_bcd[11:8]), add3(r_bcd[7:4]), add3(r_bcd[3:0])};
        w_wrap    = r_cnt == CW'(REFRESH_DIV - 1);
        w_nib     = (r_idx == 2'd2) ? r_digits[2] : (r_idx == 2'd1) ? r_digits[1] : r_digits[0];
        w_blank   = r_disp_dec && ((r_idx == 2'd2) ? r_digits[2] == 4'd0 :
                    (r_idx == 2'd1) ? (r_digits[2] == 4'd0 && r_digits[1] == 4'd0) : 1'b0);
    end

    hex_to_seg7 u_font (
        .i_nibble (w_nib),
        .i_blank  (w_blank),
        .o_seg    (w_seg)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_bin      <= '0;
            r_bcd      <= '0;
            r_shift    <= '0;
            r_cap_dec  <= 1'b0;
            r_pend     <= 1'b0;
            r_pend_val <= '0;
            r_pend_dec <= 1'b0;
            r_digits   <= '0;
            r_disp_dec <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_busy <= w_start || r_state != IDLE;
            if (load && r_state != IDLE) begin
                r_pend     <= 1'b1;
                r_pend_val <= value;
                r_pend_dec <= dec_mode;
            end else if (w_start) begin
                r_pend <= 1'b0;
            end
            if (r_state == SHIFT) begin
                {r_bcd, r_bin} <= {w_adj, r_bin} << 1;
                r_shift        <= r_shift + 3'd1;
                if (r_shift == 3'd7) r_state <= COMMIT;
            end else begin
                if (r_state == COMMIT) begin
                    r_digits   <= r_cap_dec ? r_bcd : {4'd0, r_bin};
                    r_disp_dec <= r_cap_dec;
                end
                if (w_start) begin
                    r_bin     <= w_val;
                    r_cap_dec <= w_dec;
                    r_bcd     <= '0;
                    r_shift   <= '0;
                    r_state   <= w_dec ? SHIFT : COMMIT;
                end else begin
                    r_state <= IDLE;
                end
            end
        end
    end

    // seg and an come from the same edge so the anode never shows a stale glyph.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cnt <= '0;
            r_idx <= 2'd0;
            r_an  <= '1;
            r_seg <= SEG_BLANK;
        end else begin
            r_cnt <= w_wrap ? '0 : r_cnt + CW'(1);
            if (w_wrap) r_idx <= (r_idx == 2'd2) ? 2'd0 : r_idx + 2'd1;
            r_an  <= ~(3'b001 << r_idx);
            r_seg <= w_seg;
        end
    end

    assign busy = r_busy;
    assign seg  = r_seg;
    assign an   = r_an;
endmodule
